// File: rtl/ext_int_ctrl_pkg.sv
// Shared definitions for the external interrupt controller: FSM encoding,
// the "no interrupt" code and the default code width.
package ext_int_ctrl_pkg;

   localparam int CODE_W_DEF    = 8;
   localparam int INT_CODE_NONE = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

endpackage

// File: rtl/ext_int_gateway.sv
// Per-source interrupt gateway: optional 2-flop synchronizer (EXT_INT_SYNC_EN),
// edge/level detection and a pending flop where set beats claim-clear.
module ext_int_gateway (
   input  logic clk,
   input  logic rst,
   input  logic i_irq,
   input  logic i_trig_mode,
   input  logic i_claim,
   output logic o_pending
);

   logic w_irq_s;
   logic r_prev;
   logic r_pending;
   logic w_set;

`ifdef EXT_INT_SYNC_EN
   logic r_sync1;
   logic r_sync2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_irq;
         r_sync2 <= r_sync1;
      end
   end

   assign w_irq_s = r_sync2;
`else
   assign w_irq_s = i_irq;
`endif

   // Edge mode needs a rising transition; level mode sets while high.
   assign w_set = i_trig_mode ? (w_irq_s & ~r_prev) : w_irq_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev    <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         r_prev    <= w_irq_s;
         r_pending <= w_set | (r_pending & ~i_claim);
      end
   end

   assign o_pending = r_pending;

endmodule

// File: rtl/ext_int_ctrl.sv
// External interrupt controller top: per-source gateways, fixed-priority
// arbiter (lowest index wins) and claim/complete FSM. Option: EXT_INT_SYNC_EN.
module ext_int_ctrl
   import ext_int_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 16,
   parameter int CODE_W  = CODE_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_SRC-1:0]  irq_src,
   input  logic [NUM_SRC-1:0]  trig_mode,
   input  logic [NUM_SRC-1:0]  int_enable,
   input  logic                int_claim,
   input  logic                int_complete,
   output logic                peripheral_int,
   output logic [CODE_W-1:0]   peripheral_int_code,
   output logic [NUM_SRC-1:0]  pending,
   output logic                in_service
);

   state_t              r_state, w_state_nxt;
   logic [CODE_W-1:0]   r_code, w_code_nxt;
   logic [CODE_W-1:0]   w_win_code;
   logic [NUM_SRC-1:0]  w_pending;
   logic [NUM_SRC-1:0]  w_cand;
   logic [NUM_SRC-1:0]  w_lat_sel;
   logic [NUM_SRC-1:0]  w_claim_vec;
   logic                w_lat_live;

   genvar g;
   generate
      for (g = 0; g < NUM_SRC; g++) begin : g_src
         // One-hot view of the latched code so the claim clears only that source.
         assign w_lat_sel[g]   = (r_code == CODE_W'(g + 1));
         assign w_claim_vec[g] = (r_state == ST_REQ) & int_claim & w_lat_sel[g];

         ext_int_gateway u_gw (
            .clk         (clk),
            .rst         (rst),
            .i_irq       (irq_src[g]),
            .i_trig_mode (trig_mode[g]),
            .i_claim     (w_claim_vec[g]),
            .o_pending   (w_pending[g])
         );
      end
   endgenerate

   assign w_cand     = w_pending & int_enable;
   assign w_lat_live = |(w_cand & w_lat_sel);

   always_comb begin
      w_win_code = CODE_W'(INT_CODE_NONE);
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_cand[i]) w_win_code = CODE_W'(i + 1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_code  <= CODE_W'(INT_CODE_NONE);
      end else begin
         r_state <= w_state_nxt;
         r_code  <= w_code_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_code_nxt  = r_code;
      case (r_state)
         ST_IDLE: begin
            if (|w_cand) begin
               w_code_nxt  = w_win_code;
               w_state_nxt = ST_REQ;
            end else begin
               w_code_nxt  = CODE_W'(INT_CODE_NONE);
            end
         end
         ST_REQ: begin
            // A claim takes precedence over a same-cycle enable drop.
            if (int_claim) begin
               w_state_nxt = ST_SERVICE;
            end else if (!w_lat_live) begin
               w_code_nxt  = CODE_W'(INT_CODE_NONE);
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (int_complete) begin
               w_code_nxt  = CODE_W'(INT_CODE_NONE);
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_code_nxt  = CODE_W'(INT_CODE_NONE);
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign peripheral_int      = (r_state == ST_REQ);
   assign in_service          = (r_state == ST_SERVICE);
   assign peripheral_int_code = r_code;
   assign pending             = w_pending;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Directed + randomized bench for ext_int_ctrl against a cycle-level model
// of the interrupt rules (pending set/clear and the request/service cycle).
module tb_ext_int_ctrl;

   localparam int N = 16;
   localparam int CW = 8;

   logic          clk;
   logic          rst;
   logic [N-1:0]  irq_src;
   logic [N-1:0]  trig_mode;
   logic [N-1:0]  int_enable;
   logic          int_claim;
   logic          int_complete;
   logic          peripheral_int;
   logic [CW-1:0] peripheral_int_code;
   logic [N-1:0]  pending;
   logic          in_service;

   int nchk  = 0;
   int nfail = 0;

   // Reference model state
   logic [N-1:0] m_pend;
   logic [N-1:0] m_prev;
   bit           m_req;
   bit           m_svc;
   int           m_code;

   ext_int_ctrl #(.NUM_SRC(N), .CODE_W(CW)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .irq_src             (irq_src),
      .trig_mode           (trig_mode),
      .int_enable          (int_enable),
      .int_claim           (int_claim),
      .int_complete        (int_complete),
      .peripheral_int      (peripheral_int),
      .peripheral_int_code (peripheral_int_code),
      .pending             (pending),
      .in_service          (in_service)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend = '0;
      m_prev = '0;
      m_req  = 0;
      m_svc  = 0;
      m_code = 0;
   endtask

   // One clock of the interrupt rules, using inputs present at the edge.
   task automatic model_clk();
      logic [N-1:0] cand;
      logic [N-1:0] np;
      bit           setb;
      bit           clrb;
      int           low;
      if (rst) begin
         model_reset();
         return;
      end
      cand = m_pend & int_enable;
      for (int i = 0; i < N; i++) begin
         setb  = trig_mode[i] ? (irq_src[i] && !m_prev[i]) : irq_src[i];
         clrb  = m_req && int_claim && (m_code == i + 1);
         np[i] = setb || (m_pend[i] && !clrb);
      end
      low = -1;
      for (int i = N - 1; i >= 0; i--) if (cand[i]) low = i;
      if (m_req) begin
         if (int_claim) begin
            m_req = 0;
            m_svc = 1;
         end else if (!cand[m_code-1]) begin
            m_req  = 0;
            m_code = 0;
         end
      end else if (m_svc) begin
         if (int_complete) begin
            m_svc  = 0;
            m_code = 0;
         end
      end else begin
         if (low >= 0) begin
            m_req  = 1;
            m_code = low + 1;
         end else begin
            m_code = 0;
         end
      end
      m_pend = np;
      m_prev = irq_src;
   endtask

   task automatic check_all();
      chk("peripheral_int", 32'(peripheral_int), 32'(m_req));
      chk("code",           32'(peripheral_int_code), 32'(m_code));
      chk("pending",        32'(pending), 32'(m_pend));
      chk("in_service",     32'(in_service), 32'(m_svc));
   endtask

   task automatic step();
      @(posedge clk);
      model_clk();
      #1;
      check_all();
   endtask

   task automatic pulse_claim();
      int_claim = 1'b1;
      step();
      int_claim = 1'b0;
   endtask

   task automatic pulse_complete();
      int_complete = 1'b1;
      step();
      int_complete = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      irq_src      = '0;
      trig_mode    = 16'hFF7F;   // source 7 level, rest edge
      int_enable   = '1;
      int_claim    = 1'b0;
      int_complete = 1'b0;
      model_reset();

      // 1: reset then idle
      repeat (3) step();
      rst = 1'b0;
      chk("rst_pint", 32'(peripheral_int), 0);
      chk("rst_code", 32'(peripheral_int_code), 0);
      step();

      // 2: edge source 3, latency and handshake
      irq_src = 16'h0008;
      step();
      chk("t2_pend3", 32'(pending[3]), 1);
      chk("t2_pint_n1", 32'(peripheral_int), 0);
      irq_src = '0;
      step();
      chk("t2_pint", 32'(peripheral_int), 1);
      chk("t2_code", 32'(peripheral_int_code), 4);
      pulse_claim();
      chk("t2_pend3_clr", 32'(pending[3]), 0);
      chk("t2_insvc", 32'(in_service), 1);
      pulse_complete();
      chk("t2_code0", 32'(peripheral_int_code), 0);

      // 3: simultaneous 5 and 2 -> code 3 then 6
      irq_src = 16'h0024;
      step();
      irq_src = '0;
      step();
      chk("t3_code3", 32'(peripheral_int_code), 3);
      pulse_claim();
      pulse_complete();
      step();
      chk("t3_code6", 32'(peripheral_int_code), 6);
      pulse_claim();
      pulse_complete();

      // 4: source 0 edge while servicing code 3
      irq_src = 16'h0004;
      step();
      irq_src = '0;
      step();
      pulse_claim();
      irq_src = 16'h0001;
      step();
      irq_src = '0;
      chk("t4_pend0", 32'(pending[0]), 1);
      chk("t4_pint0", 32'(peripheral_int), 0);
      step();
      pulse_complete();
      step();
      chk("t4_code1", 32'(peripheral_int_code), 1);
      pulse_claim();
      pulse_complete();

      // 5: level source 7 re-requests; enable drop aborts REQ
      irq_src = 16'h0080;
      step();
      step();
      chk("t5_code8", 32'(peripheral_int_code), 8);
      pulse_claim();
      pulse_complete();
      step();
      chk("t5_rereq", 32'(peripheral_int_code), 8);
      int_enable = 16'hFF7F;
      step();
      chk("t5_drop_pint", 32'(peripheral_int), 0);
      chk("t5_drop_code", 32'(peripheral_int_code), 0);
      irq_src    = '0;
      int_enable = '1;
      step();
      pulse_claim();
      pulse_complete();

      // 6: edge coincides with its own claim
      irq_src = 16'h0010;
      step();
      irq_src = '0;
      step();
      irq_src = 16'h0010;
      pulse_claim();
      irq_src = '0;
      chk("t6_pend4", 32'(pending[4]), 1);
      pulse_complete();
      step();
      chk("t6_code5", 32'(peripheral_int_code), 5);
      pulse_claim();
      pulse_complete();

      // Async reset mid-REQ
      irq_src = 16'h0200;
      step();
      irq_src = '0;
      step();
      rst = 1'b1;
      #1;
      model_reset();
      chk("arst_pint", 32'(peripheral_int), 0);
      chk("arst_code", 32'(peripheral_int_code), 0);
      chk("arst_pend", 32'(pending), 0);
      step();
      rst = 1'b0;

      // Randomized traffic, including stray handshake pulses
      for (int c = 0; c < 600; c++) begin
         irq_src = (($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0) & 16'($urandom);
         if ($urandom_range(0, 15) == 0) trig_mode  = 16'($urandom);
         if ($urandom_range(0, 15) == 0) int_enable = 16'($urandom) | 16'($urandom);
         int_claim    = (m_req && $urandom_range(0, 2) == 0) || ($urandom_range(0, 19) == 0);
         int_complete = (m_svc && $urandom_range(0, 2) == 0) || ($urandom_range(0, 19) == 0);
         step();
      end
      int_claim    = 1'b0;
      int_complete = 1'b0;
      irq_src      = '0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
